// File: rtl/exhaustive_stim_capture_pkg.sv
// Shared definitions for the exhaustive stimulus/capture stage.
// Holds the sweep FSM state type, pattern/counter sizing and golden
// truth-table words of reference 4-input functions, plus a helper
// that validates the DWELL / SAMPLE_AT parameter pair.
package exhaustive_stim_capture_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int NUM_PATTERNS = 16;
  localparam int IDX_W        = 4;
  localparam int CNT_W        = 8;

  // Golden truth words: bit i is f({a,b,c,d} == i)
  localparam logic [NUM_PATTERNS-1:0] XOR4 = 16'h6996;
  localparam logic [NUM_PATTERNS-1:0] AND4 = 16'h8000;
  localparam logic [NUM_PATTERNS-1:0] OR4  = 16'hFFFE;
  localparam logic [NUM_PATTERNS-1:0] NOTA = 16'h00FF;

  // The dwell counter is 8 bits and the sample point must fall inside the dwell
  function automatic logic params_ok(int dwell, int sampleAt);
    return (dwell >= 2) && (dwell <= 255) && (sampleAt >= 1) && (sampleAt <= dwell - 1);
  endfunction

endpackage

// File: rtl/exhaustive_stim_capture_if.sv
// Bus between a sweep requester and the stimulus/capture stage.
//   start, abort : sweep control from the requester
//   x            : output of the block under characterisation
//   a, b, c, d   : pattern bits 3..0 driven to the block
//   busy, done   : sweep status (done is a one-cycle pulse)
//   truth        : captured truth-table word
//   pattern_idx  : pattern currently being driven
interface exhaustive_stim_capture_if;
  import exhaustive_stim_capture_pkg::*;

  logic                    start;
  logic                    abort;
  logic                    x;
  logic                    a;
  logic                    b;
  logic                    c;
  logic                    d;
  logic                    busy;
  logic                    done;
  logic [NUM_PATTERNS-1:0] truth;
  logic [IDX_W-1:0]        pattern_idx;

  modport master (
    output start, abort, x,
    input  a, b, c, d, busy, done, truth, pattern_idx
  );

  modport slave (
    input  start, abort, x,
    output a, b, c, d, busy, done, truth, pattern_idx
  );

endinterface

// File: rtl/exhaustive_stim_capture_dwell_timer.sv
// Dwell counter for one stimulus pattern.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear_i      : return count to zero (wins over enable)
//   en_i         : advance count by one
//   sample_hit_o : count equals SAMPLE_AT (capture point)
//   last_hit_o   : count equals DWELL-1 (final cycle of the pattern)
module exhaustive_stim_capture_dwell_timer
  import exhaustive_stim_capture_pkg::*;
#(
  parameter int DWELL     = 4,
  parameter int SAMPLE_AT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic sample_hit_o,
  output logic last_hit_o
);

  localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(SAMPLE_AT);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority so a pattern change restarts the dwell
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Decodes of the registered count
  always_comb begin
    sample_hit_o = (cnt_q == SAMPLE_CNT);
    last_hit_o   = (cnt_q == LAST_CNT);
  end

endmodule

// File: rtl/exhaustive_stim_capture.sv
// Exhaustive stimulus/capture stage: walks {a,b,c,d} through 0..15,
// holds each pattern DWELL cycles and samples x at offset SAMPLE_AT,
// assembling a 16-bit truth word.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of exhaustive_stim_capture_if
module exhaustive_stim_capture
  import exhaustive_stim_capture_pkg::*;
#(
  parameter int DWELL     = 4,
  parameter int SAMPLE_AT = 3
) (
  input logic                      clk,
  input logic                      rst_n,
  exhaustive_stim_capture_if.slave bus
);

  if (!params_ok(DWELL, SAMPLE_AT)) begin : g_bad_params
    $error("exhaustive_stim_capture: DWELL must be 2..255 and SAMPLE_AT 1..DWELL-1");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PATTERNS - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        pattern_q, pattern_d;
  logic [IDX_W-1:0]        abcd_q, abcd_d;
  logic [NUM_PATTERNS-1:0] truth_q, truth_d;
  logic                    sampleHit;
  logic                    lastHit;
  logic                    timerClear;
  logic                    timerEn;

  // The dwell count only runs while driving and restarts for every pattern
  assign timerEn    = (state_q == DRIVE);
  assign timerClear = (state_q != DRIVE) || lastHit || bus.abort;

  exhaustive_stim_capture_dwell_timer #(
    .DWELL     (DWELL),
    .SAMPLE_AT (SAMPLE_AT)
  ) u_dwell_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (timerClear),
    .en_i         (timerEn),
    .sample_hit_o (sampleHit),
    .last_hit_o   (lastHit)
  );

  // State, pattern, pin and truth registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      abcd_q    <= '0;
      truth_q   <= '0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      abcd_q    <= abcd_d;
      truth_q   <= truth_d;
    end
  end

  // Next-state: abort beats start in IDLE and ends a sweep without DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (lastHit && (pattern_q == LAST_IDX)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture x at the sample point, advance the pattern at the last
  // dwell cycle; pins are registered from the next state so they change
  // together with busy
  always_comb begin
    pattern_d = pattern_q;
    truth_d   = truth_q;
    case (state_q)
      IDLE: begin
        pattern_d = '0;
        if (state_d == DRIVE) begin
          truth_d = '0;
        end
      end
      DRIVE: begin
        if (bus.abort) begin
          pattern_d = '0;
        end else begin
          if (sampleHit) begin
            truth_d[pattern_q] = bus.x;
          end
          if (lastHit && (pattern_q != LAST_IDX)) begin
            pattern_d = pattern_q + 4'd1;
          end
        end
      end
      default: pattern_d = '0;
    endcase
    abcd_d = (state_d == DRIVE) ? pattern_d : '0;
  end

  // Outputs
  always_comb begin
    bus.a           = abcd_q[3];
    bus.b           = abcd_q[2];
    bus.c           = abcd_q[1];
    bus.d           = abcd_q[0];
    bus.busy        = (state_q == DRIVE);
    bus.done        = (state_q == DONE);
    bus.truth       = truth_q;
    bus.pattern_idx = pattern_q;
  end

endmodule

// File: tb/tb_exhaustive_stim_capture.sv
// Bench for exhaustive_stim_capture: two instances (DWELL=4/SAMPLE_AT=3 and
// DWELL=2/SAMPLE_AT=1) driven by behavioural 4-input functions.
module tb_exhaustive_stim_capture;
  import exhaustive_stim_capture_pkg::*;

  localparam int M_XOR  = 0;
  localparam int M_AND  = 1;
  localparam int M_OR   = 2;
  localparam int M_NOTA = 3;

  typedef struct {
    int          which;
    int          model;
    logic [15:0] expTruth;
    int          pulseAt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   model4 = M_XOR;
  int   model2 = M_XOR;
  int   errors = 0;
  int   checks = 0;
  logic [15:0] sbQueue[$];
  vec_t vecs[6];

  always #5 clk = ~clk;

  exhaustive_stim_capture_if if4 ();
  exhaustive_stim_capture_if if2 ();

  exhaustive_stim_capture #(.DWELL(4), .SAMPLE_AT(3)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4.slave)
  );

  exhaustive_stim_capture #(.DWELL(2), .SAMPLE_AT(1)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if2.slave)
  );

  function automatic logic modelX(int m, logic [3:0] p);
    case (m)
      M_XOR:   return ^p;
      M_AND:   return &p;
      M_OR:    return |p;
      default: return ~p[3];
    endcase
  endfunction

  always_comb if4.x = modelX(model4, {if4.a, if4.b, if4.c, if4.d});
  always_comb if2.x = modelX(model2, {if2.a, if2.b, if2.c, if2.d});

  function automatic logic [3:0] getAbcd(int w);
    return (w == 0) ? {if4.a, if4.b, if4.c, if4.d} : {if2.a, if2.b, if2.c, if2.d};
  endfunction

  function automatic logic getBusy(int w);
    return (w == 0) ? if4.busy : if2.busy;
  endfunction

  function automatic logic getDone(int w);
    return (w == 0) ? if4.done : if2.done;
  endfunction

  function automatic logic [15:0] getTruth(int w);
    return (w == 0) ? if4.truth : if2.truth;
  endfunction

  function automatic logic [3:0] getIdx(int w);
    return (w == 0) ? if4.pattern_idx : if2.pattern_idx;
  endfunction

  task automatic applyStimulus(int w, logic st, logic ab);
    if (w == 0) begin
      if4.start = st;
      if4.abort = ab;
    end else begin
      if2.start = st;
      if2.abort = ab;
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Idle view of one instance: truth, busy, done, pins, index
  function automatic logic [31:0] statusWord(int w);
    return 32'({getTruth(w), getBusy(w), getDone(w), getAbcd(w), getIdx(w)});
  endfunction

  task automatic waitIdx(int w, logic [3:0] idx);
    int cyc = 0;
    while (getIdx(w) !== idx && cyc < 200) begin
      stepCycle();
      cyc++;
    end
    checkOutput("reach pattern index", 32'(getIdx(w)), 32'(idx));
  endtask

  task automatic runSweep(vec_t v);
    int          dwell;
    int          patErr;
    int          cyc;
    logic [15:0] exp;
    dwell  = (v.which == 0) ? 4 : 2;
    patErr = 0;
    if (v.which == 0) model4 = v.model;
    else model2 = v.model;
    applyStimulus(v.which, 1'b1, 1'b0);
    sbQueue.push_back(v.expTruth);
    stepCycle();
    applyStimulus(v.which, 1'b0, 1'b0);
    for (int n = 0; n < 16 * dwell; n++) begin
      if (getAbcd(v.which) !== 4'(n / dwell) || getIdx(v.which) !== 4'(n / dwell) ||
          getBusy(v.which) !== 1'b1 || getDone(v.which) !== 1'b0) begin
        patErr++;
      end
      if (n == v.pulseAt) applyStimulus(v.which, 1'b1, 1'b0);
      else applyStimulus(v.which, 1'b0, 1'b0);
      stepCycle();
    end
    checkOutput("pattern walk errors", 32'(patErr), 32'd0);
    cyc = 0;
    while (getDone(v.which) !== 1'b1 && cyc < 8) begin
      stepCycle();
      cyc++;
    end
    checkOutput("done latency", 32'(cyc), 32'd0);
    if (sbQueue.size() > 0) begin
      exp = sbQueue.pop_front();
      checkOutput("truth word", 32'(getTruth(v.which)), 32'(exp));
    end
    checkOutput("busy during done", 32'(getBusy(v.which)), 32'd0);
    stepCycle();
    checkOutput("idle after done", statusWord(v.which), 32'({v.expTruth, 10'b0}));
  endtask

  task automatic watchNoDone(int w, int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (getDone(w) === 1'b1 || getBusy(w) === 1'b1) seen++;
      stepCycle();
    end
    checkOutput("no done/busy while idle", 32'(seen), 32'd0);
  endtask

  initial begin
    vecs[0] = '{which: 0, model: M_XOR,  expTruth: 16'h6996, pulseAt: -1};
    vecs[1] = '{which: 0, model: M_AND,  expTruth: 16'h8000, pulseAt: -1};
    vecs[2] = '{which: 0, model: M_OR,   expTruth: 16'hFFFE, pulseAt: -1};
    vecs[3] = '{which: 1, model: M_NOTA, expTruth: 16'h00FF, pulseAt: -1};
    vecs[4] = '{which: 1, model: M_XOR,  expTruth: 16'h6996, pulseAt: -1};
    vecs[5] = '{which: 0, model: M_XOR,  expTruth: 16'h6996, pulseAt: 32};

    rst_n = 1'b0;
    applyStimulus(0, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0);
    repeat (3) stepCycle();
    checkOutput("reset state dut4", statusWord(0), 32'd0);
    checkOutput("reset state dut2", statusWord(1), 32'd0);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("idle after reset", statusWord(0), 32'd0);

    for (int i = 0; i < 6; i++) begin
      runSweep(vecs[i]);
      stepCycle();
    end

    // start and abort together in IDLE: abort wins, truth is left alone
    applyStimulus(0, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(0, 1'b0, 1'b0);
    checkOutput("start+abort stays idle", statusWord(0), 32'({16'h6996, 10'b0}));
    watchNoDone(0, 6);

    // abort while pattern 5 is on the pins
    model4 = M_XOR;
    applyStimulus(0, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(0, 1'b0, 1'b0);
    waitIdx(0, 4'd5);
    applyStimulus(0, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(0, 1'b0, 1'b0);
    checkOutput("abort at pattern 5", statusWord(0), 32'({16'h0016, 10'b0}));
    watchNoDone(0, 20);
    checkOutput("truth held after abort", 32'(getTruth(0)), 32'h0016);

    // asynchronous reset mid-sweep at pattern 10
    applyStimulus(0, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(0, 1'b0, 1'b0);
    waitIdx(0, 4'd10);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset mid-sweep", statusWord(0), 32'd0);
    #1;
    rst_n = 1'b1;
    watchNoDone(0, 20);
    runSweep(vecs[0]);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exhaustive_stim_capture.md
Name: exhaustive_stim_capture

Overview:
- Sequential stimulus stage that sits upstream of the team's 4-input combinational blocks and drives their inputs a, b, c, d.
- Walks all 16 input patterns in ascending order and holds each one for a programmable dwell time.
- Samples the block's single output x once per pattern and builds a 16-bit truth-table word.
- Lets a 4-input function be characterised in hardware or self-checked against a golden constant, with no hand-written vector list.

Parameters:
- DWELL, 4, clock cycles each pattern is held; legal range 2..255.
- SAMPLE_AT, 3, cycle offset within the dwell at which x is captured; legal range 1..DWELL-1.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- abort  input  1  terminates a sweep in progress.
- x  input  1  output of the downstream combinational block under characterisation.
- a  output  1  pattern bit 3 (MSB).
- b  output  1  pattern bit 2.
- c  output  1  pattern bit 1.
- d  output  1  pattern bit 0 (LSB).
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a full sweep completes.
- truth  output  16  captured results; truth[i] = x sampled while {a,b,c,d} == i.
- pattern_idx  output  4  current pattern index.

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE; a, b, c, d = 0; busy=0; done=0; truth=16'h0000; pattern_idx=0; dwell_cnt=0. Reset asserted mid-sweep aborts the sweep immediately; no done pulse.
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - On start=1 and abort=0: truth<=0, pattern_idx<=0, dwell_cnt<=0, go to DRIVE.
  - If start and abort are both high, abort wins and the FSM stays in IDLE.
  - In IDLE, a..d are driven 0 and truth holds its last value.
- DRIVE:
  - {a,b,c,d} = pattern_idx, all registered outputs.
  - busy=1.
  - dwell_cnt increments every cycle.
  - At the edge where dwell_cnt==SAMPLE_AT: truth[pattern_idx] <= x.
  - At the edge where dwell_cnt==DWELL-1: if pattern_idx==15, go to DONE; else pattern_idx++ and dwell_cnt<=0.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. pattern_idx returns to 0 on entry to IDLE.
- abort=1 in DRIVE: next state is IDLE; no done pulse; truth keeps any bits already captured; the uncaptured bits stay 0.
- start while busy is ignored; no restart, no queueing.
- Timing, with start sampled at edge k:
  - Pattern i is on a..d during cycles k+1+i*DWELL through k+(i+1)*DWELL.
  - busy is high for exactly 16*DWELL cycles.
  - done is high in cycle k+1+16*DWELL.
- truth is stable and valid from the done cycle until the next accepted start.
- dwell_cnt is 8 bits wide; pattern_idx has no wrap-around, because the sweep ends at 15.
- Out-of-range parameters are rejected by an elaboration-time check.

Decomposition:
- Shared package: the FSM state enum (IDLE, DRIVE, DONE), NUM_PATTERNS=16, IDX_W=4, and golden truth constants for existing reference functions, e.g. XOR4=16'h6996 and AND4=16'h8000.
- One natural sub-module, dwell_timer: an 8-bit counter with clear and enable that exports sample_hit (cnt==SAMPLE_AT) and last_hit (cnt==DWELL-1).
- FSM, pattern register and truth register stay in the top module.

Test Plan:
- DWELL=4, SAMPLE_AT=3, x=a^b^c^d model, single start pulse -> busy high for 64 cycles, done one pulse at cycle 65 after start, truth=16'h6996, a..d return to 0.
- Same setup with x=a&b&c&d -> truth=16'h8000; monitor checks each pattern holds exactly 4 cycles in order 0..15.
- abort asserted while pattern_idx==5 (XOR model) -> IDLE next cycle, no done, truth=16'h0016 (bits 0..4 captured, rest 0).
- start re-pulsed at pattern_idx==8, then start and abort asserted together in IDLE -> first sweep unaffected and completes with 16'h6996; simultaneous pulse leaves the FSM in IDLE.
- rst_n pulsed low mid-sweep at pattern 10 -> all outputs 0 asynchronously, truth=0, no done; a fresh start then yields a full correct sweep.
- DWELL=2, SAMPLE_AT=1, x=~a model -> busy for 32 cycles, truth=16'h00FF.
